// File: rtl/line_follow_pkg.sv
// Shared types and constants for the line-following drive controller.
//   state_e : FSM state encoding (also driven out on the state port)
//   turn_e  : remembered direction of the most recent pivot
//   DIR_*   : motor_dir codes, {left[1:0], right[1:0]}, 01 = fwd, 10 = rev, 00 = brake
package line_follow_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFollow   = 3'd1,
        StObstacle = 3'd2,
        StReverse  = 3'd3,
        StSearch   = 3'd4,
        StStop     = 3'd5
    } state_e;

    typedef enum logic {
        TurnLeft  = 1'b0,
        TurnRight = 1'b1
    } turn_e;

    localparam logic [3:0] DIR_BRAKE = 4'b0000;
    localparam logic [3:0] DIR_FWD   = 4'b0101;
    localparam logic [3:0] DIR_REV   = 4'b1010;
    localparam logic [3:0] DIR_PIV_L = 4'b1001;
    localparam logic [3:0] DIR_PIV_R = 4'b0110;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/line_follow_ctrl_if.sv
// Bundle between the sensor front end / drive pins and line_follow_ctrl.
//   enable, line, proxim, duty_fwd, duty_turn : controller inputs
//   motor_dir, motor_en, state, fault         : controller outputs
// master = environment side, slave = controller side.
interface line_follow_ctrl_if #(
    parameter int unsigned NUM_SENSORS = 3,
    parameter int unsigned PWM_W       = 8
);
    logic                   enable;
    logic [NUM_SENSORS-1:0] line;
    logic                   proxim;
    logic [PWM_W-1:0]       duty_fwd;
    logic [PWM_W-1:0]       duty_turn;
    logic [3:0]             motor_dir;
    logic [1:0]             motor_en;
    logic [2:0]             state;
    logic                   fault;

    modport master (
        output enable, line, proxim, duty_fwd, duty_turn,
        input  motor_dir, motor_en, state, fault
    );

    modport slave (
        input  enable, line, proxim, duty_fwd, duty_turn,
        output motor_dir, motor_en, state, fault
    );
endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by an optional stable-count debouncer.
//   clk, reset : clock and synchronous active-high reset
//   d_i        : asynchronous input vector
//   q_o        : synchronised (CYCLES = 0) or debounced value
// The debounced output only follows the synchronised value after it has
// differed from the output for CYCLES consecutive clocks.
module sync_debounce #(
    parameter int unsigned CYCLES = 16,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    if (CYCLES == 0) begin : g_bypass
        assign q_o = s2_q;
    end else begin : g_debounce
        localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
        localparam logic [CW-1:0] CntLast = CW'(CYCLES - 1);

        logic [CW-1:0]    cnt_q, cnt_d;
        logic [WIDTH-1:0] stable_q, stable_d;

        always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            // Any cycle where input matches output restarts the run.
            if (s2_q != stable_q) begin
                if (cnt_q == CntLast) begin
                    stable_d = s2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q    <= '0;
                stable_q <= '0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign q_o = stable_q;
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following drive controller: sensor decode, obstacle hold/reverse,
// lost-line search and fault stop, driving per-wheel direction and PWM enables.
//   clk, reset : clock and synchronous active-high reset
//   bus        : line_follow_ctrl_if.slave (enable, line, proxim, duty_fwd,
//                duty_turn in; motor_dir, motor_en, state, fault out)
// All outputs are registered from the next-state values, so a line pin change
// reaches motor_dir three clocks later (two synchroniser flops + output flop).
module line_follow_ctrl
    import line_follow_pkg::*;
#(
    parameter int unsigned NUM_SENSORS    = 3,
    parameter int unsigned PWM_W          = 8,
    parameter int unsigned PROX_DEBOUNCE  = 16,
    parameter int unsigned LOST_DELAY     = 64,
    parameter int unsigned HOLD_TIMEOUT   = 4096,
    parameter int unsigned REV_CYCLES     = 1024,
    parameter int unsigned SEARCH_TIMEOUT = 8192
) (
    input logic                clk,
    input logic                reset,
    line_follow_ctrl_if.slave  bus
);

    localparam int unsigned C    = NUM_SENSORS / 2;
    localparam int unsigned TMax = max_u(max_u(LOST_DELAY, HOLD_TIMEOUT),
                                         max_u(REV_CYCLES, SEARCH_TIMEOUT));
    localparam int unsigned TW   = $clog2(TMax + 1);

    localparam logic [TW-1:0] LostLast   = TW'(LOST_DELAY - 1);
    localparam logic [TW-1:0] HoldLast   = TW'(HOLD_TIMEOUT - 1);
    localparam logic [TW-1:0] RevLast    = TW'(REV_CYCLES - 1);
    localparam logic [TW-1:0] SearchLast = TW'(SEARCH_TIMEOUT - 1);
    localparam logic [NUM_SENSORS-1:0] LowMask = {NUM_SENSORS{1'b1}} >> (NUM_SENSORS - C);

    logic [NUM_SENSORS-1:0] line_s;
    logic                   prox_db;

    sync_debounce #(
        .CYCLES (0),
        .WIDTH  (NUM_SENSORS)
    ) u_line_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.line),
        .q_o   (line_s)
    );

    sync_debounce #(
        .CYCLES (PROX_DEBOUNCE),
        .WIDTH  (1)
    ) u_prox_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.proxim),
        .q_o   (prox_db)
    );

    // Line decode.
    logic lhit, rhit, line_none, piv_l, piv_r;
    assign lhit      = |(line_s >> (C + 1));
    assign rhit      = |(line_s & LowMask);
    assign line_none = (line_s == '0);
    assign piv_l     = lhit && !rhit;
    assign piv_r     = rhit && !lhit;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    turn_e            last_turn_q, last_turn_d;
    logic [PWM_W-1:0] cnt_q;
    logic [3:0]       dir_q, dir_d;
    logic [1:0]       en_q, en_d;
    logic             fault_q;
    logic [PWM_W-1:0] duty;

    // Next-state and per-state timer. The timer stops one short of each limit,
    // so it can never wrap.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!bus.enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: state_d = StFollow;
                StFollow: begin
                    if (prox_db) begin
                        state_d = StObstacle;
                    end else if (line_none) begin
                        if (timer_q >= LostLast) state_d = StSearch;
                        else                     timer_d = timer_q + 1'b1;
                    end else begin
                        timer_d = '0;
                    end
                end
                StObstacle: begin
                    if (!prox_db)                state_d = StFollow;
                    else if (timer_q >= HoldLast) state_d = StReverse;
                    else                          timer_d = timer_q + 1'b1;
                end
                StReverse: begin
                    if (timer_q >= RevLast) state_d = prox_db ? StObstacle : StFollow;
                    else                    timer_d = timer_q + 1'b1;
                end
                StSearch: begin
                    if (prox_db)                    state_d = StObstacle;
                    else if (!line_none)            state_d = StFollow;
                    else if (timer_q >= SearchLast) state_d = StStop;
                    else                            timer_d = timer_q + 1'b1;
                end
                StStop:  state_d = StStop;
                default: state_d = StIdle;
            endcase
        end
        if (state_d != state_q) timer_d = '0;
    end

    // Output decode from the next state, registered below.
    always_comb begin
        dir_d       = DIR_BRAKE;
        duty        = '0;
        last_turn_d = last_turn_q;
        unique case (state_d)
            StFollow: begin
                if (piv_l) begin
                    dir_d       = DIR_PIV_L;
                    duty        = bus.duty_turn;
                    last_turn_d = TurnLeft;
                end else if (piv_r) begin
                    dir_d       = DIR_PIV_R;
                    duty        = bus.duty_turn;
                    last_turn_d = TurnRight;
                end else if (!line_none) begin
                    dir_d = DIR_FWD;
                    duty  = bus.duty_fwd;
                end
            end
            StReverse: begin
                dir_d = DIR_REV;
                duty  = bus.duty_fwd;
            end
            StSearch: begin
                dir_d = (last_turn_q == TurnLeft) ? DIR_PIV_L : DIR_PIV_R;
                duty  = bus.duty_turn;
            end
            default: ;
        endcase
        en_d[1] = (dir_d[3:2] != 2'b00) && (cnt_q < duty);
        en_d[0] = (dir_d[1:0] != 2'b00) && (cnt_q < duty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            last_turn_q <= TurnLeft;
            cnt_q       <= '0;
            dir_q       <= DIR_BRAKE;
            en_q        <= 2'b00;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            last_turn_q <= last_turn_d;
            cnt_q       <= cnt_q + 1'b1;
            dir_q       <= dir_d;
            en_q        <= en_d;
            fault_q     <= (state_d == StStop);
        end
    end

    assign bus.motor_dir = dir_q;
    assign bus.motor_en  = en_q;
    assign bus.state     = state_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Scoreboard bench for line_follow_ctrl: stimulus computes the expected
// registered outputs from a behavioural model and queues them; a monitor pops
// and compares on every falling edge.
module tb_line_follow_ctrl;

    localparam int unsigned NS = 5;
    localparam int unsigned PW = 4;
    localparam int unsigned PD = 2;
    localparam int unsigned LD = 4;
    localparam int unsigned HT = 20;
    localparam int unsigned RC = 8;
    localparam int unsigned ST = 30;
    localparam int CI = NS / 2;

    localparam int S_IDLE = 0, S_FOLLOW = 1, S_OBST = 2, S_REV = 3, S_SEARCH = 4, S_STOP = 5;

    typedef struct packed {
        logic [3:0] dir;
        logic [1:0] en;
        logic [2:0] st;
        logic       flt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    line_follow_ctrl_if #(.NUM_SENSORS(NS), .PWM_W(PW)) bus ();

    line_follow_ctrl #(
        .NUM_SENSORS    (NS),
        .PWM_W          (PW),
        .PROX_DEBOUNCE  (PD),
        .LOST_DELAY     (LD),
        .HOLD_TIMEOUT   (HT),
        .REV_CYCLES     (RC),
        .SEARCH_TIMEOUT (ST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: one registered output set per clock.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("motor_dir", 32'(bus.motor_dir), 32'(e.dir));
                check("motor_en",  32'(bus.motor_en),  32'(e.en));
                check("state",     32'(bus.state),     32'(e.st));
                check("fault",     32'(bus.fault),     32'(e.flt));
            end
        end
    end

    // Behavioural model state.
    logic [NS-1:0] line_hist[$];
    logic          prox_hist[$];
    int            m_st, m_run, m_cnt, m_right, m_prun;
    logic          m_prox;

    task automatic model_reset();
        line_hist = {};
        prox_hist = {};
        repeat (2) begin
            line_hist.push_back('0);
            prox_hist.push_back(1'b0);
        end
        m_st = S_IDLE; m_run = 0; m_cnt = 0; m_right = 0; m_prox = 1'b0; m_prun = 0;
    endtask

    // Predicts the outputs that appear after the coming rising edge.
    task automatic model_edge();
        logic [NS-1:0] ls;
        logic          pr;
        logic [3:0]    dir;
        logic [PW-1:0] duty;
        exp_t          e;
        int            nst;
        bit            lh, rh, none;
        if (reset) begin
            model_reset();
            e = '0;
        end else begin
            // Inputs reach the FSM two clocks after they are sampled.
            ls = line_hist.pop_front();
            line_hist.push_back(bus.line);
            pr = prox_hist.pop_front();
            prox_hist.push_back(bus.proxim);
            lh   = (ls >> (CI + 1)) != 0;
            rh   = (ls % (1 << CI)) != 0;
            none = (ls == 0);

            nst = m_st;
            if (!bus.enable) nst = S_IDLE;
            else case (m_st)
                S_IDLE: nst = S_FOLLOW;
                S_FOLLOW: begin
                    if (m_prox) nst = S_OBST;
                    else if (none) begin
                        m_run++;
                        if (m_run == LD) nst = S_SEARCH;
                    end else m_run = 0;
                end
                S_OBST: begin
                    if (!m_prox) nst = S_FOLLOW;
                    else begin
                        m_run++;
                        if (m_run == HT) nst = S_REV;
                    end
                end
                S_REV: begin
                    m_run++;
                    if (m_run == RC) nst = m_prox ? S_OBST : S_FOLLOW;
                end
                S_SEARCH: begin
                    if (m_prox) nst = S_OBST;
                    else if (!none) nst = S_FOLLOW;
                    else begin
                        m_run++;
                        if (m_run == ST) nst = S_STOP;
                    end
                end
                default: ;
            endcase
            if (nst != m_st || !bus.enable) m_run = 0;

            // Debounce: accept after PD consecutive disagreeing samples.
            if (pr != m_prox) begin
                m_prun++;
                if (m_prun == PD) begin
                    m_prox = pr;
                    m_prun = 0;
                end
            end else m_prun = 0;

            dir  = 4'b0000;
            duty = '0;
            if (nst == S_FOLLOW) begin
                if (lh && !rh) begin
                    dir = 4'b1001; duty = bus.duty_turn; m_right = 0;
                end else if (rh && !lh) begin
                    dir = 4'b0110; duty = bus.duty_turn; m_right = 1;
                end else if (!none) begin
                    dir = 4'b0101; duty = bus.duty_fwd;
                end
            end else if (nst == S_REV) begin
                dir = 4'b1010; duty = bus.duty_fwd;
            end else if (nst == S_SEARCH) begin
                dir  = (m_right != 0) ? 4'b0110 : 4'b1001;
                duty = bus.duty_turn;
            end
            e.dir   = dir;
            e.en[1] = (dir[3:2] != 0) && (m_cnt < int'(duty));
            e.en[0] = (dir[1:0] != 0) && (m_cnt < int'(duty));
            e.st    = 3'(nst);
            e.flt   = (nst == S_STOP);
            m_cnt   = (m_cnt + 1) % (1 << PW);
            m_st    = nst;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            model_edge();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int len, mode;
        model_reset();
        reset = 1'b1; bus.enable = 1'b0; bus.line = '0; bus.proxim = 1'b0;
        bus.duty_fwd = 4'd8; bus.duty_turn = 4'd5;
        cyc(2);
        reset = 1'b0; bus.enable = 1'b1; bus.line = 5'b00100;
        cyc(20);
        bus.line = 5'b11000; cyc(8);
        bus.line = 5'b00011; cyc(8);
        bus.proxim = 1'b1; cyc(1);
        bus.proxim = 1'b0; cyc(6);
        bus.proxim = 1'b1; cyc(45);
        bus.proxim = 1'b0; cyc(6);
        bus.line = 5'b00000; cyc(10);
        bus.line = 5'b00100; cyc(5);
        bus.line = 5'b00000; cyc(50);
        bus.enable = 1'b0; cyc(3);
        bus.enable = 1'b1; bus.line = 5'b00100; cyc(5);
        bus.duty_fwd = 4'd15; cyc(20);
        bus.duty_fwd = 4'd0;  cyc(20);
        bus.duty_fwd = 4'd8;
        bus.proxim = 1'b1; cyc(30);
        reset = 1'b1; cyc(1);
        reset = 1'b0; bus.proxim = 1'b0; cyc(5);

        for (int s = 0; s < 80; s++) begin
            len  = $urandom_range(60, 4);
            mode = $urandom_range(9, 0);
            bus.duty_fwd  = PW'($urandom_range(15, 0));
            bus.duty_turn = PW'($urandom_range(15, 0));
            for (int i = 0; i < len; i++) begin
                if (mode < 3) bus.line = '0;
                else if ($urandom_range(3, 0) == 0) bus.line = NS'($urandom_range(31, 0));
                if (mode == 9) bus.proxim = 1'b1;
                else if (mode == 8) bus.proxim = ($urandom_range(2, 0) == 0);
                else bus.proxim = 1'b0;
                bus.enable = ($urandom_range(99, 0) != 0);
                reset      = ($urandom_range(499, 0) == 0);
                cyc(1);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
